// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM + MEM/WB pipeline stage with req/ack data-memory bus
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int DMEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALU_OUT_EX,
    input  logic [31:0] REG_DATA2_EX_FINAL,
    input  logic [31:0] PC_Branch_EX,
    input  logic [4:0]  RD_EX,
    input  logic [2:0]  FUNCT3_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Branch_EX,
    input  logic        ZERO_EX,
    output logic        STALL,
    output logic [31:0] ALU_OUT_MEM,
    output logic [4:0]  RD_MEM,
    output logic        RegWrite_MEM,
    output logic [31:0] PC_Branch_MEM,
    output logic        PCSrc_MEM,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    output logic [3:0]  DM_BE,
    input  logic        DM_ACK,
    input  logic [31:0] DM_RDATA,
    output logic [31:0] READ_DATA_WB,
    output logic [31:0] ALU_DATA_WB,
    output logic [4:0]  RD_WB,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic        BUS_ERR
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        MISALIGN
`endif
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(DMEM_TIMEOUT - 1);

    logic [31:0] store_data_mem;
    logic [2:0]  funct3_mem;
    logic        memtoreg_mem;
    logic        memread_mem;
    logic        memwrite_mem;
    logic        branch_mem;
    logic        zero_mem;

    state_t      state;
    logic [7:0]  wait_cnt;

    logic        mem_op;
    logic        err_abort;
    logic        ack_v;
    logic        timeout_hit;
    logic        timeout_abort;
    logic [1:0]  a;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign a      = ALU_OUT_MEM[1:0];
    assign mem_op = memread_mem | memwrite_mem;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        misaligned = 1'b0;
        if (mem_op) begin
            if ((funct3_mem == 3'b001) || (funct3_mem == 3'b101))
                misaligned = a[0];
            else if (funct3_mem == 3'b010)
                misaligned = (a != 2'b00);
        end
    end
    assign err_abort = misaligned;
`else
    assign err_abort = 1'b0;
`endif

    assign DM_REQ        = mem_op & ~err_abort;
    assign DM_WE         = memwrite_mem;
    assign DM_ADDR       = {ALU_OUT_MEM[31:2], 2'b00};
    assign ack_v         = DM_ACK & DM_REQ;
    assign timeout_hit   = (state == S_WAIT) && (wait_cnt >= TO_LAST);
    // The ack wins over a timeout landing in the same cycle.
    assign timeout_abort = timeout_hit & ~ack_v;
    assign STALL         = DM_REQ & ~DM_ACK & ~timeout_hit;
    assign PCSrc_MEM     = branch_mem & zero_mem;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data_mem;
        case (funct3_mem)
            3'b000: begin
                st_be    = 4'b0001 << a;
                st_wdata = {4{store_data_mem[7:0]}};
            end
            3'b001: begin
                st_be    = 4'b0011 << {a[1], 1'b0};
                st_wdata = {2{store_data_mem[15:0]}};
            end
            default: ;
        endcase
    end

    assign DM_BE    = memwrite_mem ? st_be : (memread_mem ? 4'b1111 : 4'b0000);
    assign DM_WDATA = memwrite_mem ? st_wdata : 32'd0;

    always_comb begin
        ld_byte = DM_RDATA[7:0];
        case (a)
            2'd0: ld_byte = DM_RDATA[7:0];
            2'd1: ld_byte = DM_RDATA[15:8];
            2'd2: ld_byte = DM_RDATA[23:16];
            2'd3: ld_byte = DM_RDATA[31:24];
            default: ;
        endcase
        ld_half = a[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
        case (funct3_mem)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = DM_RDATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_OUT_MEM    <= 32'd0;
            store_data_mem <= 32'd0;
            PC_Branch_MEM  <= 32'd0;
            RD_MEM         <= 5'd0;
            funct3_mem     <= 3'd0;
            RegWrite_MEM   <= 1'b0;
            memtoreg_mem   <= 1'b0;
            memread_mem    <= 1'b0;
            memwrite_mem   <= 1'b0;
            branch_mem     <= 1'b0;
            zero_mem       <= 1'b0;
        end else if (!STALL) begin
            ALU_OUT_MEM    <= ALU_OUT_EX;
            store_data_mem <= REG_DATA2_EX_FINAL;
            PC_Branch_MEM  <= PC_Branch_EX;
            RD_MEM         <= RD_EX;
            funct3_mem     <= FUNCT3_EX;
            RegWrite_MEM   <= RegWrite_EX;
            memtoreg_mem   <= MemtoReg_EX;
            memread_mem    <= MemRead_EX;
            memwrite_mem   <= MemWrite_EX;
            branch_mem     <= Branch_EX;
            zero_mem       <= ZERO_EX;
        end
    end

    // Counter includes the first request cycle, so it reads N in the N+1-th.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (DM_REQ && !DM_ACK) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd1;
                    end else begin
                        wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (DM_ACK || timeout_hit) begin
                        state    <= S_IDLE;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            READ_DATA_WB <= 32'd0;
            ALU_DATA_WB  <= 32'd0;
            RD_WB        <= 5'd0;
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            BUS_ERR      <= 1'b0;
        end else begin
            if (!STALL) begin
                READ_DATA_WB <= (ack_v && memread_mem) ? ld_data : 32'd0;
                ALU_DATA_WB  <= ALU_OUT_MEM;
                RD_WB        <= RD_MEM;
                RegWrite_WB  <= RegWrite_MEM & ~timeout_abort & ~err_abort;
                MemtoReg_WB  <= memtoreg_mem;
            end else begin
                RegWrite_WB  <= 1'b0;
            end
            if (timeout_abort)
                BUS_ERR <= 1'b1;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            MISALIGN <= 1'b0;
        else if (misaligned)
            MISALIGN <= 1'b1;
    end
`endif

endmodule
